axon_in_arb: RTL and testbench

AXON_IN_ARB -- requirements
Module: axon_in_arb

---
 rtl/axon_in_arb_pkg.sv | 20 ++
 rtl/axon_in_arb_rr_arb.sv | 31 +++
 rtl/axon_in_arb.sv | 88 ++++++++
 tb/tb_axon_in_arb.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/axon_in_arb_pkg.sv
// Shared node packet definitions: type encoding and width used by the axon
// and everything that feeds it.
package axon_in_arb_pkg;

  localparam int PKT_TW = 3;

  typedef enum logic [PKT_TW-1:0] {
    PKT_SPIKE    = 3'b000,
    PKT_DATA     = 3'b001,
    PKT_DATA_END = 3'b010,
    PKT_WRITE    = 3'b110,
    PKT_READ     = 3'b111
  } pkt_type_e;

  // Pointer width that stays legal for a single-port build.
  function automatic int ptr_w(input int np);
    return (np > 1) ? $clog2(np) : 1;
  endfunction

endpackage

// File: rtl/axon_in_arb_rr_arb.sv
// Combinational round-robin picker: first set bit of (req & mask) scanning
// upward from ptr with wrap. Output is one-hot or zero.
module rr_arb #(
  parameter int NP = 4,
  parameter int PW = 2
) (
  input  logic [NP-1:0] req,
  input  logic [PW-1:0] ptr,
  input  logic [NP-1:0] mask,
  output logic [NP-1:0] grant
);

  int   idx;
  logic found;

  // Scan NP positions starting at ptr; the first eligible one wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NP; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NP) idx = idx - NP;
      if (!found && req[idx] && mask[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axon_in_arb.sv
// Input arbiter in front of the axon: round-robin among single-beat packets,
// with DATA bursts locking the arbiter to one port until DATA_END.
module axon_in_arb
  import axon_in_arb_pkg::*;
#(
  parameter int NP  = 4,
  parameter int SW  = 24,
  parameter int FTW = PKT_TW,
  localparam int PW = ptr_w(NP)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NP-1:0]   req_vld,
  input  logic [NP*SW-1:0] req_data,
  input  logic [NP*FTW-1:0] req_type,
  output logic [NP-1:0]   req_rdy,
  input  logic            axon_busy,
  output logic            spk_in_axon_vld,
  output logic [SW-1:0]   spk_in_axon_data,
  output logic [FTW-1:0]  spk_in_axon_type,
  output logic            arb_lock,
  output logic [PW-1:0]   arb_lock_port
);

  logic [PW-1:0]  rr_ptr;
  logic [NP-1:0]  elig_mask;
  logic [NP-1:0]  grant;
  logic [PW-1:0]  gidx;
  logic           load_en;
  logic           xfer;
  logic [SW-1:0]  sel_data;
  logic [FTW-1:0] sel_type;
  logic [PW-1:0]  next_ptr;

  // Reset also blocks acceptance so no beat is taken while rst is high.
  assign load_en   = !axon_busy && !rst;
  assign elig_mask = arb_lock ? (NP'(1) << arb_lock_port) : {NP{1'b1}};
  assign req_rdy   = grant & {NP{load_en}};
  assign xfer      = |req_rdy;

  rr_arb #(.NP(NP), .PW(PW)) u_rr_arb (
    .req   (req_vld),
    .ptr   (rr_ptr),
    .mask  (elig_mask),
    .grant (grant)
  );

  // Encode the one-hot grant and mux out the winning port's beat.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NP; i++)
      if (grant[i]) gidx = PW'(i);
    sel_data = req_data[gidx*SW +: SW];
    sel_type = req_type[gidx*FTW +: FTW];
    next_ptr = (int'(gidx) == NP-1) ? '0 : gidx + 1'b1;
  end

  // Output register, lock state and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      spk_in_axon_vld  <= 1'b0;
      spk_in_axon_data <= '0;
      spk_in_axon_type <= '0;
      arb_lock         <= 1'b0;
      arb_lock_port    <= '0;
      rr_ptr           <= '0;
    end else begin
      spk_in_axon_vld <= xfer;
      if (xfer) begin
        spk_in_axon_data <= sel_data;
        spk_in_axon_type <= sel_type;
        if (!arb_lock && sel_type == FTW'(PKT_DATA)) begin
          // Burst start: pointer holds until release so the burst owner
          // still yields to the next port afterwards.
          arb_lock      <= 1'b1;
          arb_lock_port <= gidx;
        end else if (arb_lock && sel_type == FTW'(PKT_DATA_END)) begin
          arb_lock      <= 1'b0;
          arb_lock_port <= '0;
          rr_ptr        <= next_ptr;
        end else if (!arb_lock) begin
          rr_ptr <= next_ptr;
        end
      end
    end
  end

endmodule

// File: tb/tb_axon_in_arb.sv
// Directed bench: stimulus pushes expected output beats into a queue, a
// negedge monitor pops and compares each spk_in_axon_vld pulse.
module tb_axon_in_arb;
  localparam int NP = 4, SW = 24, FTW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    req_vld;
  logic [NP*SW-1:0] req_data;
  logic [NP*FTW-1:0] req_type;
  logic [NP-1:0]    req_rdy;
  logic             axon_busy;
  logic             spk_in_axon_vld;
  logic [SW-1:0]    spk_in_axon_data;
  logic [FTW-1:0]   spk_in_axon_type;
  logic             arb_lock;
  logic [1:0]       arb_lock_port;

  axon_in_arb #(.NP(NP), .SW(SW), .FTW(FTW)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data),
    .req_type(req_type), .req_rdy(req_rdy), .axon_busy(axon_busy),
    .spk_in_axon_vld(spk_in_axon_vld), .spk_in_axon_data(spk_in_axon_data),
    .spk_in_axon_type(spk_in_axon_type), .arb_lock(arb_lock),
    .arb_lock_port(arb_lock_port)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [SW+FTW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_port(input int p, input logic v, input logic [2:0] t, input logic [23:0] d);
    req_vld[p] = v;
    req_type[p*FTW +: FTW] = t;
    req_data[p*SW +: SW] = d;
  endtask

  task automatic push(input logic [2:0] t, input logic [23:0] d);
    exp_q.push_back({d, t});
  endtask

  // Inputs are set right after a negedge; check req_rdy, then step to the next negedge.
  task automatic step(input string name, input logic [3:0] rdy);
    #1;
    check(name, 32'(req_rdy), 32'(rdy));
    @(negedge clk);
  endtask

  // Scoreboard monitor: every output pulse must match the next expected beat.
  always @(negedge clk) begin
    if (spk_in_axon_vld === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_beat: got %0h/%0h expected none", spk_in_axon_data, spk_in_axon_type);
      end else begin
        logic [SW+FTW-1:0] e;
        e = exp_q.pop_front();
        if ({spk_in_axon_data, spk_in_axon_type} !== e) begin
          n_bad++;
          $display("FAIL beat: got %0h/%0h expected %0h/%0h",
                   spk_in_axon_data, spk_in_axon_type, e[SW+FTW-1:FTW], e[FTW-1:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; axon_busy = 1'b0;
    req_vld = '0; req_data = '0; req_type = '0;
    set_port(0, 1'b1, 3'b000, 24'h5);
    @(negedge clk);
    step("rdy_in_reset", 4'b0000);
    check("rst_vld", 32'(spk_in_axon_vld), 0);
    check("rst_data", 32'(spk_in_axon_data), 0);
    check("rst_type", 32'(spk_in_axon_type), 0);
    check("rst_lock", 32'(arb_lock), 0);
    check("rst_lock_port", 32'(arb_lock_port), 0);
    rst = 1'b0; req_vld = '0;

    // Four SPIKE ports held: 0,1,2,3,0 back-to-back.
    for (int i = 0; i < 4; i++) set_port(i, 1'b1, 3'b000, 24'hA0 + 24'(i));
    push(0, 24'hA0); push(0, 24'hA1); push(0, 24'hA2); push(0, 24'hA3); push(0, 24'hA0);
    step("rr_g0", 4'b0001); step("rr_g1", 4'b0010); step("rr_g2", 4'b0100);
    step("rr_g3", 4'b1000); step("rr_g0b", 4'b0001);
    req_vld = '0;
    step("rr_idle", 4'b0000);

    // Port 1 burst vs port 2 SPIKE.
    set_port(2, 1'b1, 3'b000, 24'hB2);
    set_port(1, 1'b1, 3'b001, 24'h000011);
    push(1, 24'h000011); push(1, 24'h000022); push(2, 24'h000033); push(0, 24'hB2);
    step("burst_b0", 4'b0010);
    check("burst_lock", 32'(arb_lock), 1);
    check("burst_lock_port", 32'(arb_lock_port), 1);
    set_port(1, 1'b1, 3'b001, 24'h000022);
    step("burst_b1", 4'b0010);
    set_port(1, 1'b1, 3'b010, 24'h000033);
    step("burst_b2", 4'b0010);
    check("burst_unlock", 32'(arb_lock), 0);
    req_vld[1] = 1'b0;
    step("burst_next_p2", 4'b0100);
    req_vld = '0;
    step("burst_idle", 4'b0000);

    // Busy axon blocks port 3 for 9 cycles after port 0 SPIKE.
    set_port(0, 1'b1, 3'b000, 24'hC0);
    push(0, 24'hC0); push(0, 24'hC3);
    step("busy_p0", 4'b0001);
    req_vld[0] = 1'b0;
    set_port(3, 1'b1, 3'b000, 24'hC3);
    axon_busy = 1'b1;
    for (int i = 0; i < 9; i++) step("busy_block", 4'b0000);
    axon_busy = 1'b0;
    step("busy_release_p3", 4'b1000);
    req_vld = '0;
    step("busy_idle", 4'b0000);

    // DATA_END while unlocked is a single beat; pointer moves to 3.
    set_port(2, 1'b1, 3'b010, 24'hD2);
    push(2, 24'hD2); push(0, 24'hD3); push(0, 24'hD0);
    step("dend_p2", 4'b0100);
    check("dend_no_lock", 32'(arb_lock), 0);
    req_vld[2] = 1'b0;
    set_port(0, 1'b1, 3'b000, 24'hD0);
    set_port(3, 1'b1, 3'b000, 24'hD3);
    step("dend_ptr3", 4'b1000);
    req_vld[3] = 1'b0;
    step("dend_then_p0", 4'b0001);
    req_vld = '0;
    step("dend_idle", 4'b0000);

    // Reset mid-burst.
    set_port(1, 1'b1, 3'b001, 24'hE1);
    push(1, 24'hE1);
    step("rst_burst_p1", 4'b0010);
    check("rst_burst_locked", 32'(arb_lock), 1);
    req_vld = '0; rst = 1'b1;
    step("rst_pulse_rdy", 4'b0000);
    rst = 1'b0;
    check("post_rst_vld", 32'(spk_in_axon_vld), 0);
    check("post_rst_lock", 32'(arb_lock), 0);
    set_port(0, 1'b1, 3'b000, 24'hF0);
    set_port(1, 1'b1, 3'b001, 24'hF1);
    push(0, 24'hF0); push(1, 24'hF1); push(2, 24'hF2);
    step("post_rst_p0", 4'b0001);
    req_vld[0] = 1'b0;
    step("post_rst_p1", 4'b0010);
    check("post_rst_lock_port", 32'(arb_lock_port), 1);
    set_port(1, 1'b1, 3'b010, 24'hF2);
    step("post_rst_p1_end", 4'b0010);
    req_vld = '0;
    step("post_rst_idle", 4'b0000);

    // Locked port 3 goes quiet for 5 cycles while port 0 waits.
    set_port(3, 1'b1, 3'b001, 24'h31);
    set_port(0, 1'b1, 3'b000, 24'h30);
    push(1, 24'h31); push(2, 24'h32); push(0, 24'h30);
    step("hol_p3", 4'b1000);
    req_vld[3] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hol_lock", 32'(arb_lock), 1);
      check("hol_lock_port", 32'(arb_lock_port), 3);
      step("hol_stall", 4'b0000);
    end
    set_port(3, 1'b1, 3'b010, 24'h32);
    step("hol_p3_end", 4'b1000);
    req_vld[3] = 1'b0;
    check("hol_unlock", 32'(arb_lock), 0);
    step("hol_then_p0", 4'b0001);
    req_vld = '0;

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
